wb_dual_master_arbiter: RTL and testbench

- Sits between the vscale CPU's two Wishbone masters (instruction `iwbm`, data `dwbm`) and the shared slave path that the bus-matrix address decode feeds (RAM, ROM, UART).
- Grants one master at a time onto a single slave port. Arbitration is round-robin; the grant is held for the whole cycle, including CTI bursts.
- Optionally adds a bus watchdog that terminates hung transfers with `err`.

---
 rtl/wb_soc_pkg.sv | 29 ++
 rtl/wb_arb_watchdog.sv | 43 ++++
 rtl/wb_dual_master_arbiter.sv | 160 ++++++++++++++++
 tb/tb_wb_dual_master_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_soc_pkg.sv
// Shared definitions for the Wishbone SoC fabric around the vscale core.
//
// Contents:
//   gnt_state_t     grant FSM states (IDLE/GNT0/GNT1). The encoding equals the
//                   one-hot grant vector {m1,m0}, so the state drives gnt_o
//                   directly.
//   CTI_* / BTE_*   Wishbone registered-feedback cycle and burst type codes.
//   TIMEOUT_DEFAULT default bus watchdog limit in clock cycles.
package wb_soc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_GNT0 = 2'b01,
    ST_GNT1 = 2'b10
  } gnt_state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Bus watchdog for the dual-master arbiter.
//
// Counts cycles in which the granted request is strobed but the slave has not
// answered. When the count reaches TIMEOUT a single-cycle err pulse is raised
// and the count restarts.
//
// Ports:
//   clk      in  clock
//   rst      in  synchronous active-high reset
//   busy     in  s_cyc_o & s_stb_o
//   resp     in  any slave response (ack | err | rty)
//   gnt_chg  in  grant changes on the coming edge
//   fire     out one-cycle timeout error toward the granted master
module wb_arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  input  logic resp,
  input  logic gnt_chg,
  output logic fire
);

  // The count reaches TIMEOUT in the same cycle the TIMEOUT-th stall is seen,
  // so the pulse fires when the registered count is one short of the limit.
  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  logic [15:0] cnt;
  logic        stalled;

  assign stalled = busy & ~resp;
  assign fire    = stalled & (cnt == LIMIT);

  always_ff @(posedge clk) begin
    if (rst || resp || gnt_chg || fire) begin
      cnt <= '0;
    end else if (stalled) begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/wb_dual_master_arbiter.sv
// Round-robin arbiter joining the vscale instruction (m0) and data (m1)
// Wishbone masters onto one slave port. The grant is registered and held for
// the whole cyc, bursts included; all request/response muxing is combinational
// from the grant.
//
// Optional feature: define WB_DUAL_MASTER_ARBITER_TIMEOUT_EN to add a bus
// watchdog that answers a hung strobed transfer with err after TIMEOUT cycles.
//
// Ports:
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   m0_* / m1_*               master request inputs and response outputs
//   s_*_o / s_*_i             slave request outputs and response inputs
//   gnt_o                     one-hot grant {m1,m0}, 00 when idle
module wb_dual_master_arbiter
  import wb_soc_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic [2:0]      m0_cti_i,
  input  logic [1:0]      m0_bte_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic            m0_rty_o,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic [2:0]      m1_cti_i,
  input  logic [1:0]      m1_bte_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            m1_rty_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic [2:0]      s_cti_o,
  output logic [1:0]      s_bte_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  input  logic            s_rty_i,
  output logic [1:0]      gnt_o
);

  gnt_state_t state;
  gnt_state_t state_next;
  logic       last_m1;   // last granted master was m1
  logic       sel0;
  logic       sel1;
  logic       wd_err;

  // Next-grant decision: a granted master keeps the bus until it drops cyc,
  // then hands over directly to a waiting master without an idle cycle.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_next = last_m1 ? ST_GNT0 : ST_GNT1;
        else if (m0_cyc_i)        state_next = ST_GNT0;
        else if (m1_cyc_i)        state_next = ST_GNT1;
        else                      state_next = ST_IDLE;
      end
      ST_GNT0: begin
        if (!m0_cyc_i) state_next = m1_cyc_i ? ST_GNT1 : ST_IDLE;
      end
      ST_GNT1: begin
        if (!m1_cyc_i) state_next = m0_cyc_i ? ST_GNT0 : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state   <= ST_IDLE;
      last_m1 <= 1'b1;
    end else begin
      state <= state_next;
      if (state_next != state && state_next == ST_GNT0) last_m1 <= 1'b0;
      if (state_next != state && state_next == ST_GNT1) last_m1 <= 1'b1;
    end
  end

  assign gnt_o = state;
  assign sel0  = (state == ST_GNT0);
  assign sel1  = (state == ST_GNT1);

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_cti_o = '0;
    s_bte_o = '0;
    if (sel0) begin
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
      s_we_o  = m0_we_i;
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i;
      s_cti_o = m0_cti_i;
      s_bte_o = m0_bte_i;
    end else if (sel1) begin
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
      s_we_o  = m1_we_i;
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i;
      s_cti_o = m1_cti_i;
      s_bte_o = m1_bte_i;
    end
  end

`ifdef WB_DUAL_MASTER_ARBITER_TIMEOUT_EN
  wb_arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .busy   (s_cyc_o & s_stb_o),
    .resp   (s_ack_i | s_err_i | s_rty_i),
    .gnt_chg(state_next != state),
    .fire   (wd_err)
  );
`else
  assign wd_err = 1'b0;
`endif

  // Read data is fanned out unconditionally; only the handshakes are steered.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = sel0 & s_ack_i;
  assign m1_ack_o = sel1 & s_ack_i;
  assign m0_err_o = sel0 & (s_err_i | wd_err);
  assign m1_err_o = sel1 & (s_err_i | wd_err);
  assign m0_rty_o = sel0 & s_rty_i;
  assign m1_rty_o = sel1 & s_rty_i;

endmodule

// File: tb/tb_wb_dual_master_arbiter.sv
// Testbench for wb_dual_master_arbiter: directed scenarios followed by random
// traffic, all compared every cycle against an ownership-level reference model.
module tb_wb_dual_master_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
`ifdef WB_DUAL_MASTER_ARBITER_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   m0_adr, m1_adr, s_adr;
  logic [DW-1:0]   m0_wdat, m1_wdat, s_wdat, s_rdat, m0_rdat, m1_rdat;
  logic [DW/8-1:0] m0_sel, m1_sel, s_sel;
  logic            m0_we, m1_we, s_we, m0_cyc, m1_cyc, s_cyc, m0_stb, m1_stb, s_stb;
  logic [2:0]      m0_cti, m1_cti, s_cti;
  logic [1:0]      m0_bte, m1_bte, s_bte, gnt;
  logic            m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
  logic            s_ack, s_err, s_rty;

  int checks = 0;
  int errors = 0;

  // Reference model: which master owns the bus (0 none, 1 = m0, 2 = m1),
  // who owned it last, and how long the current owner has been stalled.
  int own;
  int last;
  int wd_cnt;

  always #5 clk = ~clk;

  wb_dual_master_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_cti_i(m0_cti), .m0_bte_i(m0_bte),
    .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_rty_o(m0_rty),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_cti_i(m1_cti), .m1_bte_i(m1_bte),
    .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_rty_o(m1_rty),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_sel_o(s_sel), .s_we_o(s_we),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_cti_o(s_cti), .s_bte_o(s_bte),
    .s_dat_i(s_rdat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
    .gnt_o(gnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit owner_cyc();
    return (own == 1) ? m0_cyc : (own == 2) ? m1_cyc : 1'b0;
  endfunction

  function automatic bit wd_fire();
    bit stb_o;
    bit stalled;
    stb_o   = (own == 1) ? m0_stb : (own == 2) ? m1_stb : 1'b0;
    stalled = owner_cyc() && stb_o && !(s_ack || s_err || s_rty);
    return WD_EN && stalled && (wd_cnt == TO - 1);
  endfunction

  // Compare every DUT output against what the model's current owner implies.
  task automatic sample();
    logic [1:0]    e_gnt;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_wdat;
    logic [2:0]    e_cti;
    logic          e_stb, e_we;
    bit            f;
    @(negedge clk);
    f      = wd_fire();
    e_gnt  = (own == 1) ? 2'b01 : (own == 2) ? 2'b10 : 2'b00;
    e_adr  = (own == 1) ? m0_adr  : (own == 2) ? m1_adr  : '0;
    e_wdat = (own == 1) ? m0_wdat : (own == 2) ? m1_wdat : '0;
    e_cti  = (own == 1) ? m0_cti  : (own == 2) ? m1_cti  : '0;
    e_stb  = (own == 1) ? m0_stb  : (own == 2) ? m1_stb  : 1'b0;
    e_we   = (own == 1) ? m0_we   : (own == 2) ? m1_we   : 1'b0;
    chk("gnt", gnt, e_gnt);
    chk("s_cyc", s_cyc, owner_cyc());
    chk("s_stb", s_stb, e_stb);
    chk("s_we", s_we, e_we);
    chk("s_adr", s_adr, e_adr);
    chk("s_dat", s_wdat, e_wdat);
    chk("s_cti", s_cti, e_cti);
    chk("m0_ack", m0_ack, (own == 1) && s_ack);
    chk("m1_ack", m1_ack, (own == 2) && s_ack);
    chk("m0_err", m0_err, (own == 1) && (s_err || f));
    chk("m1_err", m1_err, (own == 2) && (s_err || f));
    chk("m0_rty", m0_rty, (own == 1) && s_rty);
    chk("m1_rty", m1_rty, (own == 2) && s_rty);
    chk("m0_dat", m0_rdat, s_rdat);
    chk("m1_dat", m1_rdat, s_rdat);
  endtask

  // Apply the arbitration rules to the current inputs, then clock.
  task automatic advance();
    int  nxt;
    bit  f;
    bit  stalled;
    f       = wd_fire();
    stalled = owner_cyc() && s_stb && !(s_ack || s_err || s_rty);
    if (rst) begin
      nxt  = 0;
      last = 2;
    end else begin
      if (own != 0 && owner_cyc()) nxt = own;
      else begin
        bit want0, want1;
        want0 = m0_cyc && own != 1;
        want1 = m1_cyc && own != 2;
        if (own == 0 && m0_cyc && m1_cyc) nxt = (last == 1) ? 2 : 1;
        else if (want0) nxt = 1;
        else if (want1) nxt = 2;
        else nxt = 0;
      end
      if (nxt != own && nxt != 0) last = nxt;
    end
    if (rst || nxt != own || s_ack || s_err || s_rty || f) wd_cnt = 0;
    else if (stalled) wd_cnt++;
    own = nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic randomize_fields();
    m0_adr  = $urandom; m1_adr  = $urandom;
    m0_wdat = $urandom; m1_wdat = $urandom;
    m0_sel  = 4'($urandom); m1_sel = 4'($urandom);
    m0_we   = 1'($urandom); m1_we  = 1'($urandom);
    m0_bte  = 2'($urandom); m1_bte = 2'($urandom);
    s_rdat  = $urandom;
  endtask

  initial begin
    int pulses;
    int pos;
    randomize_fields();
    m0_cti = 3'b000; m1_cti = 3'b000;
    s_ack = 0; s_err = 0; s_rty = 0;

    // Reset held with both masters requesting and a spurious ack.
    rst = 1; m0_cyc = 1; m1_cyc = 1; m0_stb = 1; m1_stb = 1;
    @(posedge clk); #1;
    own = 0; last = 2; wd_cnt = 0;
    s_ack = 1;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("rst_gnt", gnt, 2'b00);
      chk("rst_acks", {m0_ack, m1_ack}, 2'b00);
      advance();
    end
    rst = 0; s_ack = 0;
    tick();
    sample();
    chk("first_gnt_m0", gnt, 2'b01);
    advance();

    // Single read from m1 with a two-cycle slave wait.
    m0_cyc = 0; m1_cyc = 0; m0_stb = 0; m1_stb = 0;
    tick();
    tick();
    m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 32'h0000_0100;
    tick();
    tick();
    tick();
    s_ack = 1; s_rdat = 32'hDEADBEEF;
    sample();
    chk("rd_m1_ack", m1_ack, 1'b1);
    chk("rd_m1_dat", m1_rdat, 32'hDEADBEEF);
    chk("rd_m0_ack", m0_ack, 1'b0);
    advance();
    m1_cyc = 0; m1_stb = 0; s_ack = 0;
    tick();

    // Contention from idle: m0 first, then alternation without idle bubbles.
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    tick();
    s_ack = 1;
    sample();
    chk("cont_gnt0", gnt, 2'b01);
    advance();
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    tick();
    sample();
    chk("cont_gnt1", gnt, 2'b10);
    advance();
    m0_cyc = 1; m0_stb = 1; s_ack = 1;
    tick();
    m1_cyc = 0; m1_stb = 0; s_ack = 0;
    tick();
    sample();
    chk("cont_gnt2", gnt, 2'b01);
    advance();

    // Four-beat INCR burst on m1 while m0 keeps requesting.
    m0_cyc = 0; m0_stb = 0; m1_cyc = 1; m1_stb = 1;
    tick();
    m0_cyc = 1; m0_stb = 1;
    for (int b = 0; b < 4; b++) begin
      m1_cti = (b < 3) ? 3'b010 : 3'b111;
      m1_adr = 32'h0000_2000 + 32'(4 * b);
      s_ack  = 1;
      sample();
      chk("burst_gnt", gnt, 2'b10);
      chk("burst_ack", m1_ack, 1'b1);
      advance();
    end
    m1_cyc = 0; m1_stb = 0; m1_cti = 3'b000; s_ack = 0;
    tick();
    sample();
    chk("post_burst_gnt", gnt, 2'b01);
    advance();

    // Reset during beat 2 of an m0 burst.
    m0_cti = 3'b010; s_ack = 1;
    tick();
    rst = 1;
    tick();
    sample();
    chk("abort_cyc", s_cyc, 1'b0);
    chk("abort_gnt", gnt, 2'b00);
    chk("abort_ack", m0_ack, 1'b0);
    advance();
    rst = 0; m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0; s_ack = 0; m0_cti = 3'b000;
    tick();
    tick();

    // Unresponsive slave behind an m0 strobe.
    m0_cyc = 1; m0_stb = 1;
    tick();
    pulses = 0; pos = 0;
    for (int k = 1; k <= 12; k++) begin
      sample();
      if (m0_err) begin
        pulses++;
        pos = k;
      end
      advance();
    end
    chk("wd_pulses", pulses, WD_EN ? 1 : 0);
    chk("wd_cycle", pos, WD_EN ? TO : 0);
    m0_cyc = 0; m0_stb = 0;
    tick();
    tick();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      randomize_fields();
      if ($urandom_range(3) == 0) m0_cyc = ~m0_cyc;
      if ($urandom_range(3) == 0) m1_cyc = ~m1_cyc;
      m0_stb = m0_cyc & ($urandom_range(3) != 0);
      m1_stb = m1_cyc & ($urandom_range(3) != 0);
      m0_cti = 3'($urandom); m1_cti = 3'($urandom);
      s_ack  = ($urandom_range(2) == 0);
      s_err  = ($urandom_range(7) == 0);
      s_rty  = ($urandom_range(7) == 0);
      rst    = ($urandom_range(49) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
